cv32e40p_dbg_halt_ctrl: RTL and testbench
=========================================

// Module: cv32e40p_dbg_halt_ctrl
// PURPOSE
//  Debug-module-side halt/resume controller directly upstream of the core debug interface.
//  Accepts host commands (HALT / RESUME / ACK_HAVERESET) over a valid/ready port.
//  Drives debug_req and the halt/exception vectors into the core.
//  Consumes the core's havereset/running/halted status and returns a one-cycle response per command.
// PARAMETERS
//  HALT_ADDR       32'h1A11_0800  value driven on dm_halt_addr_o
//  EXC_ADDR        32'h1A11_1000  value driven on dm_exception_addr_o
//  TIMEOUT_CYCLES  1024           max cycles waiting for halted/running before TIMEOUT (>=2)
//  TO_W            16             timeout counter width; TIMEOUT_CYCLES < 2**TO_W
// PORTS
//  clk_i                in   1   clock, all logic on posedge
//  rst_i                in   1   synchronous reset, active-high
//  cmd_valid_i          in   1   host command valid
//  cmd_ready_o          out  1   controller can accept command (IDLE only)
//  cmd_op_i             in   2   01 HALT, 10 RESUME, 11 ACK_HAVERESET, 00 illegal
//  rsp_valid_o          out  1   one-cycle response pulse, no backpressure
//  rsp_status_o         out  2   00 OK, 01 TIMEOUT, 10 ILLEGAL; valid with rsp_valid_o
//  debug_req_o          out  1   debug request to core
//  resume_req_o         out  1   resume flag to debug ROM (ROM executes dret)
//  dm_halt_addr_o       out  32  = HALT_ADDR
//  dm_exception_addr_o  out  32  = EXC_ADDR
//  debug_havereset_i    in   1   core status
//  debug_running_i      in   1   core status
//  debug_halted_i       in   1   core status
//  havereset_sticky_o   out  1   set by debug_havereset_i, cleared by ACK_HAVERESET
//  status_err_o         out  1   sticky: running and halted seen high together
// BEHAVIOUR
//  Reset values:
//   - debug_req_o=0, resume_req_o=0, rsp_valid_o=0, rsp_status_o=00.
//   - havereset_sticky_o=0, status_err_o=0, cmd_ready_o=0, FSM=IDLE, counter=0.
//   - Address outputs are constant parameters, independent of reset.
//  FSM states: IDLE, HALT_WAIT, RESUME_WAIT, RSP.
//   - cmd_ready_o=1 only in IDLE with rst_i low.
//   - Accept = cmd_valid_i & cmd_ready_o.
//  IDLE, on accept:
//   - HALT, core already halted -> RSP(OK).
//   - HALT, otherwise -> HALT_WAIT; debug_req_o=1 from the next cycle.
//   - RESUME, debug_halted_i=1 -> RESUME_WAIT; resume_req_o=1 from the next cycle.
//   - RESUME, debug_halted_i=0 -> RSP(ILLEGAL).
//   - ACK_HAVERESET -> clear sticky; RSP(OK).
//   - op 00 -> RSP(ILLEGAL).
//  HALT_WAIT:
//   - debug_req_o held 1; counter increments every cycle.
//   - debug_halted_i=1 -> debug_req_o=0 next cycle; RSP(OK).
//   - counter==TIMEOUT_CYCLES-1 -> debug_req_o=0; RSP(TIMEOUT).
//   - halted and timeout in the same cycle -> OK wins.
//  RESUME_WAIT:
//   - resume_req_o held 1.
//   - debug_running_i=1 -> resume_req_o=0; RSP(OK).
//   - Timeout -> resume_req_o=0; RSP(TIMEOUT).
//  RSP:
//   - rsp_valid_o=1 for exactly one cycle, then IDLE; counter cleared.
//   - Accept-to-rsp latency: 1 cycle for immediate ops; N+1 for waits, N = cycles to status.
//  Sticky rules:
//   - havereset_sticky_o sets the cycle after debug_havereset_i=1.
//   - Set beats ACK clear in the same cycle.
//   - status_err_o sets if debug_running_i & debug_halted_i; cleared only by reset.
//  Reset mid-operation: next edge forces the reset values.
//   - Any pending command is dropped with no response.
//   - debug_req_o drops the same edge.
// CONFIGURATION
//  CV32E40P_DBG_HALT_TIMEOUT_EN
//   - Defined: timeout counter present; behaviour as above.
//   - Undefined: no counter; HALT_WAIT/RESUME_WAIT wait indefinitely; status 01 never produced.
//   - rsp_status_o encoding is unchanged either way.
// TESTING
//  1. Core running; HALT; halted rises 5 cycles after accept.
//     -> debug_req_o high 5 cycles, drops next cycle; rsp OK at accept+6.
//  2. Timeout enabled, TIMEOUT_CYCLES=8; HALT, halted never rises.
//     -> debug_req_o high 8 cycles; rsp_status=01; cmd_ready_o high next cycle.
//  3. Core halted; RESUME; running rises 3 cycles later.
//     -> resume_req_o high 3 cycles; rsp OK.
//  4. Core running; RESUME.
//     -> rsp ILLEGAL next cycle, debug_req_o and resume_req_o stay 0.
//  5. debug_havereset_i pulse -> sticky=1; ACK_HAVERESET -> sticky=0, rsp OK.
//     ACK coinciding with a new havereset pulse -> sticky stays 1.
//  6. rst_i asserted during HALT_WAIT -> next edge: debug_req_o=0, no rsp_valid_o.
//     After release: cmd_ready_o=1.

Source files
------------

// File: rtl/cv32e40p_dbg_halt_ctrl.sv
// Debug-module-side halt/resume controller for the CV32E40P debug interface.
// Takes HALT / RESUME / ACK_HAVERESET host commands, drives debug_req and the
// resume flag into the core, and returns a one-cycle response per command.
// Optional feature macro: CV32E40P_DBG_HALT_TIMEOUT_EN (wait-state timeout counter).
module cv32e40p_dbg_halt_ctrl #(
  parameter logic [31:0] HALT_ADDR      = 32'h1A11_0800,
  parameter logic [31:0] EXC_ADDR       = 32'h1A11_1000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_status_o,
  output logic        debug_req_o,
  output logic        resume_req_o,
  output logic [31:0] dm_halt_addr_o,
  output logic [31:0] dm_exception_addr_o,
  input  logic        debug_havereset_i,
  input  logic        debug_running_i,
  input  logic        debug_halted_i,
  output logic        havereset_sticky_o,
  output logic        status_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    HALT_WAIT,
    RESUME_WAIT,
    RSP
  } state_e;

  localparam logic [1:0] OP_HALT    = 2'b01;
  localparam logic [1:0] OP_RESUME  = 2'b10;
  localparam logic [1:0] OP_ACK     = 2'b11;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  // Reject configurations where the counter cannot reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 32'd2 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_bad_cfg
    $error("cv32e40p_dbg_halt_ctrl: TIMEOUT_CYCLES must be >= 2 and < 2**TO_W");
  end

  state_e     state_q, state_d;
  logic [1:0] status_q, status_d;
  logic       sticky_q;
  logic       err_q;
  logic       accept;
  logic       ack_accept;
  logic       timeout_hit;

  assign dm_halt_addr_o      = HALT_ADDR;
  assign dm_exception_addr_o = EXC_ADDR;

  assign cmd_ready_o        = (state_q == IDLE) && !rst_i;
  assign accept             = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o        = (state_q == RSP);
  assign rsp_status_o       = status_q;
  assign debug_req_o        = (state_q == HALT_WAIT);
  assign resume_req_o       = (state_q == RESUME_WAIT);
  assign havereset_sticky_o = sticky_q;
  assign status_err_o       = err_q;

`ifdef CV32E40P_DBG_HALT_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q;

  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in a wait state; zero everywhere else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == HALT_WAIT || state_q == RESUME_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and response-status selection.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    ack_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RSP;
          case (cmd_op_i)
            OP_HALT: begin
              if (debug_halted_i) status_d = ST_OK;
              else                state_d  = HALT_WAIT;
            end
            OP_RESUME: begin
              if (debug_halted_i) state_d  = RESUME_WAIT;
              else                status_d = ST_ILLEGAL;
            end
            OP_ACK: begin
              ack_accept = 1'b1;
              status_d   = ST_OK;
            end
            default: status_d = ST_ILLEGAL;
          endcase
        end
      end
      // Completion is checked before timeout so a coincident halt reports OK.
      HALT_WAIT: begin
        if (debug_halted_i) begin
          state_d  = RSP;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          state_d  = RSP;
          status_d = ST_TIMEOUT;
        end
      end
      RESUME_WAIT: begin
        if (debug_running_i) begin
          state_d  = RSP;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          state_d  = RSP;
          status_d = ST_TIMEOUT;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, response status and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      status_q <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (debug_havereset_i) sticky_q <= 1'b1;
      else if (ack_accept)   sticky_q <= 1'b0;
      if (debug_running_i && debug_halted_i) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_dbg_halt_ctrl.sv
// Self-checking bench for cv32e40p_dbg_halt_ctrl: directed scenarios plus
// randomized commands checked against a transaction-level latency model.
module tb_cv32e40p_dbg_halt_ctrl;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] HADDR = 32'h1A11_0800;
  localparam logic [31:0] EADDR = 32'h1A11_1000;
`ifdef CV32E40P_DBG_HALT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic        rsp_valid_o;
  logic [1:0]  rsp_status_o;
  logic        debug_req_o;
  logic        resume_req_o;
  logic [31:0] dm_halt_addr_o;
  logic [31:0] dm_exception_addr_o;
  logic        debug_havereset_i;
  logic        debug_running_i;
  logic        debug_halted_i;
  logic        havereset_sticky_o;
  logic        status_err_o;

  int  errors = 0;
  int  checks = 0;
  bit  m_sticky = 1'b0;
  bit  m_err = 1'b0;
  bit  hr_random = 1'b0;

  cv32e40p_dbg_halt_ctrl #(
    .HALT_ADDR      (HADDR),
    .EXC_ADDR       (EADDR),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (16)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_op_i            (cmd_op_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_status_o        (rsp_status_o),
    .debug_req_o         (debug_req_o),
    .resume_req_o        (resume_req_o),
    .dm_halt_addr_o      (dm_halt_addr_o),
    .dm_exception_addr_o (dm_exception_addr_o),
    .debug_havereset_i   (debug_havereset_i),
    .debug_running_i     (debug_running_i),
    .debug_halted_i      (debug_halted_i),
    .havereset_sticky_o  (havereset_sticky_o),
    .status_err_o        (status_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; update the sticky-flag model from the inputs about to be sampled.
  task automatic step(input bit ack_now);
    if (hr_random) debug_havereset_i = ($urandom_range(0, 7) == 0);
    if (rst_i) begin
      m_sticky = 1'b0;
      m_err    = 1'b0;
    end else begin
      if (debug_havereset_i) m_sticky = 1'b1;
      else if (ack_now)      m_sticky = 1'b0;
      if (debug_running_i && debug_halted_i) m_err = 1'b1;
    end
    @(posedge clk_i);
    #1;
    check_eq("havereset_sticky", havereset_sticky_o, m_sticky);
    check_eq("status_err", status_err_o, m_err);
  endtask

  // Issue one command. n = cycles after accept at which the awaited status rises.
  task automatic run_cmd(input logic [1:0] op, input bit start_halted, input int n);
    int lat;
    logic [1:0] st;
    bit hw, rw;
    hw = 1'b0;
    rw = 1'b0;
    lat = 1;
    st = 2'b00;
    debug_halted_i  = start_halted;
    debug_running_i = !start_halted;
    case (op)
      2'b01:   hw = !start_halted;
      2'b10: begin
        rw = start_halted;
        if (!start_halted) st = 2'b10;
      end
      2'b11:   st = 2'b00;
      default: st = 2'b10;
    endcase
    if (hw || rw) begin
      if (TO_EN && n > int'(TMO)) begin
        lat = TMO + 1;
        st  = 2'b01;
      end else begin
        lat = n + 1;
        st  = 2'b00;
      end
    end
    check_eq("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    step(op == 2'b11);
    for (int c = 1; c <= lat + 1; c++) begin
      check_eq("debug_req", debug_req_o, hw && (c < lat));
      check_eq("resume_req", resume_req_o, rw && (c < lat));
      check_eq("rsp_valid", rsp_valid_o, c == lat);
      if (c == lat) check_eq("rsp_status", rsp_status_o, st);
      check_eq("cmd_ready", cmd_ready_o, c == lat + 1);
      if (c <= lat) begin
        cmd_valid_i = ($urandom_range(0, 3) == 0);
        cmd_op_i    = 2'($urandom_range(0, 3));
        if (c == n && hw) begin
          debug_halted_i  = 1'b1;
          debug_running_i = 1'b0;
        end
        if (c == n && rw) begin
          debug_running_i = 1'b1;
          debug_halted_i  = 1'b0;
        end
        step(1'b0);
      end
    end
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i = 2'b00;
    debug_havereset_i = 1'b0;
    debug_running_i = 1'b1;
    debug_halted_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_debug_req", debug_req_o, 1'b0);
    check_eq("rst_resume_req", resume_req_o, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_rsp_status", rsp_status_o, 2'b00);
    check_eq("rst_sticky", havereset_sticky_o, 1'b0);
    check_eq("rst_err", status_err_o, 1'b0);
    check_eq("rst_cmd_ready", cmd_ready_o, 1'b0);
    check_eq("halt_addr", dm_halt_addr_o, HADDR);
    check_eq("exc_addr", dm_exception_addr_o, EADDR);
    rst_i = 1'b0;
    step(1'b0);

    // Directed: halt after 5 cycles, resume after 3, resume while running, illegal op.
    run_cmd(2'b01, 1'b0, 5);
    run_cmd(2'b01, 1'b1, 0);
    run_cmd(2'b10, 1'b1, 3);
    run_cmd(2'b10, 1'b0, 0);
    run_cmd(2'b00, 1'b0, 0);

`ifdef CV32E40P_DBG_HALT_TIMEOUT_EN
    // Timeout boundaries: never halts, halts on the timeout cycle, one cycle late.
    run_cmd(2'b01, 1'b0, 1000);
    run_cmd(2'b01, 1'b0, TMO);
    run_cmd(2'b01, 1'b0, TMO + 1);
    run_cmd(2'b10, 1'b1, 1000);
`endif

    // Havereset sticky: set, acknowledge, then acknowledge with a coincident pulse.
    debug_havereset_i = 1'b1;
    step(1'b0);
    debug_havereset_i = 1'b0;
    step(1'b0);
    run_cmd(2'b11, 1'b0, 0);
    debug_havereset_i = 1'b1;
    step(1'b0);
    run_cmd(2'b11, 1'b0, 0);
    debug_havereset_i = 1'b0;
    run_cmd(2'b11, 1'b0, 0);

    // Randomized command mix with random havereset pulses.
    hr_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step(1'b0);
        check_eq("idle_ready", cmd_ready_o, 1'b1);
        check_eq("idle_debug_req", debug_req_o, 1'b0);
      end
    end
    hr_random = 1'b0;
    debug_havereset_i = 1'b0;

    // Running and halted together latches status_err.
    debug_running_i = 1'b1;
    debug_halted_i  = 1'b1;
    step(1'b0);
    debug_halted_i = 1'b0;
    step(1'b0);

    // Reset during HALT_WAIT drops the command without a response.
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b01;
    step(1'b0);
    cmd_valid_i = 1'b0;
    check_eq("mid_debug_req", debug_req_o, 1'b1);
    step(1'b0);
    rst_i = 1'b1;
    step(1'b0);
    check_eq("mrst_debug_req", debug_req_o, 1'b0);
    check_eq("mrst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("mrst_cmd_ready", cmd_ready_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check_eq("post_rst_ready", cmd_ready_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      check_eq("post_rst_rsp_valid", rsp_valid_o, 1'b0);
      check_eq("post_rst_debug_req", debug_req_o, 1'b0);
      check_eq("post_rst_cmd_ready", cmd_ready_o, 1'b1);
    end
    run_cmd(2'b01, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
